uart_tx_arbiter: RTL and testbench

Shares one `uart_prat` transmitter among `NUM_REQ` byte producers using round-robin arbitration. Each requester hands over a byte with a valid/ready handshake. The block pulses `tx_start`, holds `tx_data` stable for the whole frame, waits for `tx_done`, and then reports completion to the owning requester. It sits between the producer blocks and the transmitter. A watchdog recovers the arbiter if `tx_done` never arrives.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rr_arbiter.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit arbiter:
//                FSM state encoding, data width, default watchdog constant
//                and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_W       = 8;
   localparam int UART_CLKS_PER_BIT = 16;
   // start + 8 data + stop
   localparam int UART_FRAME_BITS   = 10;
   // two full frame times, a generous bound for a healthy transmitter
   localparam int UART_WDOG_DEFAULT = 2 * UART_FRAME_BITS * UART_CLKS_PER_BIT;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } arb_state_e;

   // Width of a saturating counter able to hold 'limit' (minimum one bit of value)
   function automatic int cnt_width(input int limit);
      return $clog2((limit < 1) ? 1 : limit) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin selector. Searches the request
//                vector starting one above 'ptr' with wrap-around and returns
//                a one-hot grant plus the encoded winner index.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int IDX_W = $clog2(NUM_REQ);
   // one extra bit so ptr+offset (< 2*NUM_REQ) never overflows
   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // First pending request at ptr+1, ptr+2, ... ptr+NUM_REQ (ptr itself last)
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         sum = SUM_W'(ptr) + SUM_W'(off);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter among NUM_REQ byte producers.
//                Round-robin grant, one-cycle tx_start, tx_data held for the
//                frame, per-requester completion pulse, optional inter-frame
//                gap and optional watchdog on tx_done.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             req_done,
   output logic                           tx_start,
   output logic [UART_DATA_W-1:0]         tx_data,
   input  logic                           tx_done,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     owner,
   output logic                           timeout_err
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int GAP_W = cnt_width(GAP_CYCLES);
   localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);

   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [TO_W-1:0]  TO_MAX   = '1;

   arb_state_e             state_q,       state_d;
   logic [IDX_W-1:0]       ptr_q,         ptr_d;
   logic [IDX_W-1:0]       owner_q,       owner_d;
   logic [UART_DATA_W-1:0] tx_data_q,     tx_data_d;
   logic                   tx_start_q,    tx_start_d;
   logic [NUM_REQ-1:0]     req_done_q,    req_done_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [GAP_W-1:0]       gap_cnt_q,     gap_cnt_d;
   logic [TO_W-1:0]        to_cnt_q,      to_cnt_d;

   logic [NUM_REQ-1:0]     win_grant;
   logic [IDX_W-1:0]       win_idx;
   logic                   handshake;
   logic                   wdog_fire;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (win_grant),
      .idx   (win_idx)
   );

   assign req_ready = (state_q == ST_IDLE) ? win_grant : '0;
   assign handshake = |(req_valid & req_ready);
   // watchdog fires on the TIMEOUT_CYCLES-th WAIT_DONE clock without tx_done
   assign wdog_fire = (TIMEOUT_CYCLES != 0) && !tx_done && (to_cnt_q == TO_LAST);

   // Next-state and next-output computation for the arbitration FSM
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      req_done_d    = '0;
      timeout_err_d = 1'b0;
      gap_cnt_d     = gap_cnt_q;
      to_cnt_d      = to_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               state_d    = ST_START;
               ptr_d      = win_idx;
               owner_d    = win_idx;
               tx_data_d  = req_data[int'(win_idx)*UART_DATA_W +: UART_DATA_W];
               tx_start_d = 1'b1;
            end
         end
         ST_START: begin
            // tx_done is deliberately not looked at here: a level left over
            // from the previous frame must not complete this one
            state_d  = ST_WAIT_DONE;
            to_cnt_d = '0;
         end
         ST_WAIT_DONE: begin
            if (tx_done || wdog_fire) begin
               if (tx_done) begin
                  req_done_d = NUM_REQ'(1) << owner_q;
               end else begin
                  timeout_err_d = 1'b1;
               end
               if (GAP_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (to_cnt_q != TO_MAX) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= GAP_W'(1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched frame data and registered output pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= IDX_W'(NUM_REQ - 1);
         owner_q       <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         req_done_q    <= '0;
         timeout_err_q <= 1'b0;
         gap_cnt_q     <= '0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         req_done_q    <= req_done_d;
         timeout_err_q <= timeout_err_d;
         gap_cnt_q     <= gap_cnt_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign req_done    = req_done_q;
   assign timeout_err = timeout_err_q;
   assign owner       = owner_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter. The stimulus process
//                plays producers and transmitter and predicts each grant and
//                completion (who, what byte, which cycle); a monitor process
//                checks DUT outputs against those predictions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int GAP  = 3;
   localparam int TMO  = 20;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] req_valid, req_ready, req_done;
   logic [8*NREQ-1:0] req_data;
   logic            tx_start, tx_done, busy, timeout_err;
   logic [7:0]      tx_data;
   logic [1:0]      owner;

   uart_tx_arbiter #(
      .NUM_REQ        (NREQ),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .req_done    (req_done),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int idx; int data; int cyc; } grant_t;
   typedef struct { bit to; int idx; int cyc; }   cmpl_t;

   grant_t exp_g[$];
   cmpl_t  exp_c[$];
   int     n_vec = 0;
   int     n_bad = 0;

   logic [NREQ-1:0] v_m;
   logic [7:0]      d_m [NREQ];
   int              ptr_m;
   int              last_cmpl;
   int              cur_data;
   bit              in_frame = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic apply();
      req_valid = v_m;
      for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = d_m[i];
   endtask

   task automatic check_reset_values();
      chk("rst_tx_start",    int'(tx_start),    0);
      chk("rst_req_done",    int'(req_done),    0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_busy",        int'(busy),        0);
      chk("rst_owner",       int'(owner),       0);
      chk("rst_tx_data",     int'(tx_data),     0);
      chk("rst_req_ready",   int'(req_ready),   0);
   endtask

   // mode 0: random traffic, 1: fixed round-robin set, 2: lone req2,
   // 3: lone req1 aborted by reset while waiting for tx_done
   task automatic frame(input int mode);
      int win, hs, d, endc, k;
      bit hang, stale;
      @(negedge clk);
      case (mode)
         0: begin
            for (int i = 0; i < NREQ; i++)
               if (!v_m[i] && $urandom_range(0, 1) == 1) begin
                  v_m[i] = 1'b1;
                  d_m[i] = 8'($urandom);
               end
            if (v_m == '0) begin
               k = $urandom_range(0, NREQ - 1);
               v_m[k] = 1'b1;
               d_m[k] = 8'($urandom);
            end
         end
         2: begin v_m = '0; v_m[2] = 1'b1; d_m[2] = 8'hC3; end
         3: begin v_m = '0; v_m[1] = 1'b1; d_m[1] = 8'h5A; end
         default: ;
      endcase
      apply();
      // reference arbitration: first pending requester after the last served
      win = -1;
      for (int o = 1; o <= NREQ; o++)
         if (win < 0 && v_m[(ptr_m + o) % NREQ]) win = (ptr_m + o) % NREQ;
      ptr_m = win;
      hs = (last_cmpl + 1 + GAP > cyc + 1) ? last_cmpl + 1 + GAP : cyc + 1;
      exp_g.push_back('{idx: win, data: int'(d_m[win]), cyc: hs});
      hang  = (mode == 3) || ((mode == 0) && ($urandom_range(0, 5) == 0));
      stale = (mode == 0) && ($urandom_range(0, 2) == 0);
      d     = (mode == 0) ? int'($urandom_range(0, 6)) : 2;
      endc  = hang ? hs + 1 + TMO : hs + 2 + d;
      if (mode != 3) begin
         exp_c.push_back('{to: hang, idx: win, cyc: endc});
         last_cmpl = endc;
      end
      while (cyc < hs - 1) @(negedge clk);
      #1;
      chk("ready_onehot", int'(req_ready), 1 << win);
      chk("busy_before_grant", int'(busy), 0);
      do begin
         @(negedge clk);
         if (cyc == hs) begin
            if (mode != 1) v_m[win] = 1'b0;
            if (mode == 0)
               for (int i = 0; i < NREQ; i++) begin
                  if (i != win && v_m[i] && $urandom_range(0, 3) == 0) v_m[i] = 1'b0;
                  else if (!v_m[i] && $urandom_range(0, 2) == 0) begin
                     v_m[i] = 1'b1;
                     d_m[i] = 8'($urandom);
                  end
               end
            apply();
         end
         tx_done = (stale && cyc == hs) || (!hang && cyc == hs + 1 + d);
         if (mode == 3 && cyc == hs + 3) begin
            v_m = '0;
            apply();
            #2 rst = 1'b0;
            #1 check_reset_values();
            @(negedge clk);
            rst       = 1'b1;
            ptr_m     = NREQ - 1;
            last_cmpl = -100;
            return;
         end
      end while (cyc < endc);
   endtask

   // Monitor: match every start and completion against the predictions
   initial begin
      grant_t g;
      cmpl_t  c;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            in_frame = 1'b0;
         end else begin
            if (in_frame && req_done == '0 && !timeout_err) begin
               chk("tx_data_hold", int'(tx_data), cur_data);
               chk("busy_in_frame", int'(busy), 1);
            end
            if (tx_start) begin
               if (exp_g.size() == 0) chk("unexpected_start", 1, 0);
               else begin
                  g = exp_g.pop_front();
                  chk("grant_owner", int'(owner), g.idx);
                  chk("grant_data", int'(tx_data), g.data);
                  chk("start_cycle", cyc, g.cyc);
                  cur_data = g.data;
                  in_frame = 1'b1;
               end
            end
            if (req_done != '0 || timeout_err) begin
               if (exp_c.size() == 0) chk("unexpected_completion", 1, 0);
               else begin
                  c = exp_c.pop_front();
                  chk("req_done_vec", int'(req_done), c.to ? 0 : (1 << c.idx));
                  chk("timeout_flag", int'(timeout_err), int'(c.to));
                  chk("completion_cycle", cyc, c.cyc);
               end
               in_frame = 1'b0;
            end
         end
      end
   end

   // Stimulus
   initial begin
      tx_done = 1'b0;
      v_m     = '0;
      for (int i = 0; i < NREQ; i++) d_m[i] = 8'h00;
      apply();
      ptr_m     = NREQ - 1;
      last_cmpl = -100;
      repeat (3) @(negedge clk);
      #1 check_reset_values();
      @(negedge clk);
      rst = 1'b1;

      v_m = '1;
      d_m[0] = 8'h11; d_m[1] = 8'h22; d_m[2] = 8'h33; d_m[3] = 8'h44;
      repeat (5) frame(1);
      repeat (40) frame(0);
      frame(3);
      frame(2);

      repeat (GAP + 4) @(negedge clk);
      chk("grants_outstanding", exp_g.size(), 0);
      chk("completions_outstanding", exp_c.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
